// File: rtl/ring_phase_monitor_if.sv
// Bundle between a ring-counter source and the phase monitor: the sampled ring
// word and error clear one way, decoded phase and health indications the other.
interface ring_phase_monitor_if #(
   parameter int WIDTH = 16,
   parameter int IDXW  = 4,
   parameter int REV_W = 8
);
   logic [WIDTH-1:0] ring_in;
   logic             clr_err;
   logic [IDXW-1:0]  phase_idx;
   logic             phase_valid;
   logic             locked;
   logic [REV_W-1:0] rev_count;
   logic             rev_pulse;
   logic             err_illegal;
   logic             err_skip;
   logic             err_sticky;

   modport master (
      output ring_in, clr_err,
      input  phase_idx, phase_valid, locked, rev_count, rev_pulse,
             err_illegal, err_skip, err_sticky
   );

   modport slave (
      input  ring_in, clr_err,
      output phase_idx, phase_valid, locked, rev_count, rev_pulse,
             err_illegal, err_skip, err_sticky
   );
endinterface

// File: rtl/ring_phase_monitor.sv
// Decodes a one-hot ring counter into a phase index, tracks lock on a steady
// one-step-per-cycle advance, counts revolutions and flags illegal/skipped steps.
module ring_phase_monitor #(
   parameter int WIDTH    = 16,
   parameter int IDXW     = 4,
   parameter int LOCK_CNT = 4,
   parameter int REV_W    = 8
) (
   input  logic clk,
   input  logic reset,
   ring_phase_monitor_if.slave mon
);

   localparam int STW = 4;

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t           state;
   logic [STW-1:0]   streak;
   logic [IDXW-1:0]  prev_idx;

   logic             is_legal;
   logic [IDXW-1:0]  hot_idx;
   logic [IDXW-1:0]  next_idx;
   logic             is_advance;
   logic             is_hold;
   logic             is_skip;
   logic             is_wrap;
   logic [STW-1:0]   next_streak;
   logic             err_set;

   // A word is one-hot when it is non-zero and clearing its lowest set bit leaves nothing.
   always_comb begin
      is_legal = (mon.ring_in != '0) &&
                 ((mon.ring_in & (mon.ring_in - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);
   end

   always_comb begin
      hot_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (mon.ring_in[i]) begin
            hot_idx = IDXW'(i);
         end
      end
   end

   always_comb begin
      next_idx    = prev_idx + IDXW'(1);
      is_advance  = is_legal && (hot_idx == next_idx);
      is_hold     = is_legal && (hot_idx == prev_idx);
      is_skip     = is_legal && !is_advance && !is_hold;
      is_wrap     = is_advance && (hot_idx == '0);
      next_streak = streak + STW'(1);
      err_set     = (state == LOCKED) && (!is_legal || is_skip);
   end

   // Single registered FSM; every output is a flop updated from the current sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= SYNC;
         streak          <= '0;
         prev_idx        <= '0;
         mon.phase_idx   <= '0;
         mon.phase_valid <= 1'b0;
         mon.locked      <= 1'b0;
         mon.rev_count   <= '0;
         mon.rev_pulse   <= 1'b0;
         mon.err_illegal <= 1'b0;
         mon.err_skip    <= 1'b0;
         mon.err_sticky  <= 1'b0;
      end else begin
         mon.phase_valid <= is_legal;
         mon.rev_pulse   <= 1'b0;
         mon.err_illegal <= 1'b0;
         mon.err_skip    <= 1'b0;

         if (is_legal) begin
            mon.phase_idx <= hot_idx;
            prev_idx      <= hot_idx;
         end

         // Set has priority so an error coinciding with a clear is never lost.
         if (err_set) begin
            mon.err_sticky <= 1'b1;
         end else if (mon.clr_err) begin
            mon.err_sticky <= 1'b0;
         end

         case (state)
            SYNC: begin
               mon.locked <= 1'b0;
               if (is_legal) begin
                  state  <= TRACK;
                  streak <= '0;
               end
            end

            TRACK: begin
               mon.locked <= 1'b0;
               if (!is_legal) begin
                  state  <= SYNC;
                  streak <= '0;
               end else if (is_advance) begin
                  if (next_streak == STW'(LOCK_CNT)) begin
                     state      <= LOCKED;
                     streak     <= '0;
                     mon.locked <= 1'b1;
                  end else begin
                     streak <= next_streak;
                  end
               end else if (is_skip) begin
                  streak <= '0;
               end
            end

            LOCKED: begin
               mon.locked <= 1'b1;
               if (!is_legal) begin
                  state           <= SYNC;
                  streak          <= '0;
                  mon.locked      <= 1'b0;
                  mon.err_illegal <= 1'b1;
               end else if (is_skip) begin
                  state        <= TRACK;
                  streak       <= '0;
                  mon.locked   <= 1'b0;
                  mon.err_skip <= 1'b1;
               end else if (is_wrap) begin
                  mon.rev_count <= mon.rev_count + REV_W'(1);
                  mon.rev_pulse <= 1'b1;
               end
            end

            default: begin
               state      <= SYNC;
               streak     <= '0;
               mon.locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Self-checking bench: directed walk through lock/revolution/error scenarios, then
// randomized ring traffic, all scored against a behavioural model of the monitor.
module tb_ring_phase_monitor;

   logic clk;
   logic reset;

   ring_phase_monitor_if #(.WIDTH(16), .IDXW(4), .REV_W(8)) bus ();

   ring_phase_monitor #(
      .WIDTH(16), .IDXW(4), .LOCK_CNT(4), .REV_W(8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .mon   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Behavioural model: mode 0 = hunting, 1 = counting good steps, 2 = locked
   int m_mode, m_streak, m_prev, m_revs;
   int e_idx, e_valid, e_locked, e_pulse, e_ill, e_skip, e_sticky;
   logic [15:0] cur;

   task automatic checkOutput(input string tag, input int obs, input int expv);
      total++;
      if (obs != expv) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic modelReset();
      m_mode = 0; m_streak = 0; m_prev = 0; m_revs = 0;
      e_idx = 0; e_valid = 0; e_locked = 0; e_pulse = 0;
      e_ill = 0; e_skip = 0; e_sticky = 0;
   endtask

   task automatic modelStep(input logic [15:0] s, input logic c);
      bit legal, adv, hold;
      int idx;
      legal = ($countones(s) == 1);
      idx   = legal ? $clog2(s) : 0;
      adv   = legal && (idx == (m_prev + 1) % 16);
      hold  = legal && (idx == m_prev);
      e_pulse = 0; e_ill = 0; e_skip = 0;
      if (m_mode == 0) begin
         if (legal) begin m_mode = 1; m_streak = 0; end
      end else if (m_mode == 1) begin
         if (!legal) begin m_mode = 0; m_streak = 0; end
         else if (adv) begin
            m_streak++;
            if (m_streak == 4) begin m_mode = 2; m_streak = 0; end
         end else if (!hold) m_streak = 0;
      end else begin
         if (!legal) begin e_ill = 1; m_mode = 0; m_streak = 0; end
         else if (adv && idx == 0) begin m_revs = (m_revs + 1) % 256; e_pulse = 1; end
         else if (!adv && !hold) begin e_skip = 1; m_mode = 1; m_streak = 0; end
      end
      if (e_ill || e_skip) e_sticky = 1;
      else if (c) e_sticky = 0;
      if (legal) begin e_idx = idx; m_prev = idx; end
      e_valid  = legal;
      e_locked = (m_mode == 2);
   endtask

   task automatic checkAll();
      checkOutput("phase_idx",   int'(bus.phase_idx),   e_idx);
      checkOutput("phase_valid", int'(bus.phase_valid), e_valid);
      checkOutput("locked",      int'(bus.locked),      e_locked);
      checkOutput("rev_count",   int'(bus.rev_count),   m_revs);
      checkOutput("rev_pulse",   int'(bus.rev_pulse),   e_pulse);
      checkOutput("err_illegal", int'(bus.err_illegal), e_ill);
      checkOutput("err_skip",    int'(bus.err_skip),    e_skip);
      checkOutput("err_sticky",  int'(bus.err_sticky),  e_sticky);
   endtask

   task automatic applyStimulus(input logic [15:0] s, input logic c);
      @(negedge clk);
      bus.ring_in = s;
      bus.clr_err = c;
      @(posedge clk);
      modelStep(s, c);
      #1 checkAll();
   endtask

   function automatic logic [15:0] rotl(input logic [15:0] v);
      return {v[14:0], v[15]};
   endfunction

   task automatic advance();
      cur = rotl(cur);
      applyStimulus(cur, 1'b0);
   endtask

   int pulses;
   int r;
   logic [15:0] w;

   initial begin
      reset = 1'b0;
      bus.ring_in = 16'h0003;
      bus.clr_err = 1'b0;
      modelReset();
      repeat (3) @(posedge clk);
      #1 checkAll();

      @(negedge clk);
      reset = 1'b1;
      applyStimulus(16'h0000, 1'b0);
      applyStimulus(16'h0000, 1'b0);

      // Lock acquisition
      cur = 16'h0001;
      applyStimulus(cur, 1'b0);
      repeat (4) advance();
      checkOutput("locked_after_0010", int'(bus.locked), 1);

      // Revolutions with a mid-run hold
      pulses = 0;
      for (int i = 0; i < 32; i++) begin
         advance();
         pulses += int'(bus.rev_pulse);
         if (cur == 16'h0020) begin
            repeat (2) begin
               applyStimulus(cur, 1'b0);
               pulses += int'(bus.rev_pulse);
            end
         end
      end
      checkOutput("pulse_count", pulses, 2);
      checkOutput("revs_two", int'(bus.rev_count), 2);

      // Illegal while locked, then relock
      applyStimulus(16'h0003, 1'b0);
      repeat (6) advance();

      // Skip while locked, then relock
      while (cur != 16'h0004) advance();
      cur = 16'h0010;
      applyStimulus(cur, 1'b0);
      checkOutput("skip_idx", int'(bus.phase_idx), 4);
      repeat (4) advance();

      // Clear collides with an error: set must win; then clear alone
      applyStimulus(16'h0003, 1'b1);
      applyStimulus(16'h0003, 1'b1);
      applyStimulus(cur, 1'b0);
      repeat (6) advance();

      // Asynchronous reset between edges
      @(posedge clk);
      #2 reset = 1'b0;
      modelReset();
      #1 checkAll();
      @(negedge clk);
      reset = 1'b1;

      // Randomized traffic
      cur = 16'h0001;
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 99);
         if (r < 70) cur = rotl(cur);
         else if (r < 80) cur = cur;
         else if (r < 88) cur = 16'h0001 << $urandom_range(0, 15);
         if (r < 88) w = cur;
         else if (r < 96) w = 16'($urandom);
         else w = 16'h0000;
         applyStimulus(w, ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
- Downstream consumer of the 16-bit one-hot ring counter output.
- Samples the ring word every clock and encodes the hot bit to a binary phase index.
- Checks that the counter advances one position per step, locking after a run of correct steps; counts full revolutions; flags illegal patterns and skipped steps.
- Feeds phase-select and sequencing logic, and drives a health/error indication.

Parameters:
- WIDTH, 16, ring width in bits; power of two, ≥4.
- IDXW, 4, phase index width; equals log2(WIDTH).
- LOCK_CNT, 4, consecutive correct advances required to enter LOCKED; range 1..15.
- REV_W, 8, revolution counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- ring_in  input  WIDTH  ring counter output; bit i hot means phase i.
- clr_err  input  1  synchronous clear of err_sticky.
- phase_idx  output  IDXW  index of the hot bit in the last legal sample.
- phase_valid  output  1  last sample was exactly one-hot.
- locked  output  1  monitor is in LOCKED.
- rev_count  output  REV_W  completed revolutions while locked; wraps modulo 2^REV_W.
- rev_pulse  output  1  one-cycle strobe on each counted revolution.
- err_illegal  output  1  one-cycle strobe: non-one-hot sample while locked.
- err_skip  output  1  one-cycle strobe: one-hot sample that is neither a hold nor a +1 advance, while locked.
- err_sticky  output  1  latched OR of both error strobes.

Behaviour:
- Reset (reset=0, async): all outputs 0; FSM=SYNC; streak=0; prev_idx=0.
- Sampling and latency:
  - ring_in is sampled on every rising edge; all outputs are registered.
  - Outputs reflect the sample taken at that edge: 1-cycle latency.
- Classification of a sample S:
  - legal: popcount(S)==1, with idx = position of the hot bit.
  - advance: legal and idx == (prev_idx+1) mod WIDTH; this includes the wrap WIDTH-1→0.
  - hold: legal and idx == prev_idx; permitted, never an error.
  - skip: legal but neither advance nor hold.
  - illegal: not legal; this includes all-zero and multi-hot.
- phase_valid = legal.
- On a legal sample, phase_idx and prev_idx are updated to idx. On an illegal sample, both hold their previous values.
- FSM SYNC:
  - locked=0; no error strobes.
  - Legal sample → TRACK, streak=0.
  - Otherwise stay in SYNC.
- FSM TRACK:
  - locked=0; no error strobes.
  - advance → streak+1; if the new streak equals LOCK_CNT → LOCKED, and locked=1 from that edge.
  - hold → stay; streak unchanged.
  - skip → stay in TRACK; streak=0; the new idx becomes the reference.
  - illegal → SYNC; streak=0.
- FSM LOCKED:
  - locked=1.
  - advance from WIDTH-1 to 0 → rev_count+1 (wraps), rev_pulse=1 for one cycle.
  - Any other advance, or a hold → no action.
  - illegal → err_illegal=1 for one cycle, err_sticky=1, → SYNC, locked=0 at that edge.
  - skip → err_skip=1 for one cycle, err_sticky=1, → TRACK with streak=0, locked=0 at that edge.
- Revolution rules:
  - rev_count is cleared only by reset; it holds across loss of lock.
  - A wrap seen in TRACK (including the lock-completing advance) is not counted.
- err_sticky:
  - Set by either error strobe.
  - Cleared by clr_err=1 at a clock edge.
  - Simultaneous set and clear → set wins (remains 1).
- Reset asserted mid-operation: immediate return to reset values, regardless of clock.
- Exactly one of advance/hold/skip/illegal applies to any sample in TRACK or LOCKED.

Test Plan:
- Reset: hold reset=0 with ring_in=0x0003, toggle clk → all outputs 0. Release, keep ring_in=0x0000 → phase_valid=0, locked=0, no errors.
- Lock acquisition: drive 0x0001, 0x0002, 0x0004, 0x0008, 0x0010 on successive edges → phase_idx 0,1,2,3,4; locked=1 after the edge sampling 0x0010; err_sticky=0.
- Revolutions: continue rotate-left for 32 more samples (through 0x8000→0x0001 twice) → rev_pulse high exactly 2 cycles, each one the edge after 0x0001 is sampled; rev_count=2. Repeat 0x0020 for 3 cycles mid-run → no error, lock retained.
- Illegal while locked: inject 0x0003 → err_illegal for one cycle, err_sticky=1, locked=0, phase_idx unchanged. Resume a legal rotation → relocks after LOCK_CNT advances; rev_count unchanged.
- Skip while locked: after relock, jump 0x0004→0x0010 → err_skip for one cycle, locked=0, phase_idx=4, FSM in TRACK. Four further correct advances → locked=1.
- Sticky clear: clr_err=1 together with an illegal sample while locked → err_sticky stays 1. clr_err=1 alone next cycle → err_sticky=0. Assert reset mid-rotation between edges → outputs 0 immediately.
